cam_8x8: RTL and testbench

- 8-entry, 8-bit-wide content-addressable memory.
- Each entry has its own parallel load port (data0..data7). An 8-bit per-entry write mask (addr) selects which entries load on a write cycle.
- A search compares data_in against all valid entries in parallel and returns a one-hot-per-entry match vector on srch0..srch7. status reports which entries hold valid data.
- Used as a small lookup/tag-match block beside a controller that owns the entry contents.

---
 rtl/cam_8x8.sv | 115 +++++++++++
 tb/tb_cam_8x8.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/cam_8x8.sv
// ============================================================================
// Module   : cam_8x8
// Purpose  : 8-entry CAM with per-entry parallel load, masked write, and a
//            registered parallel search. Optional macro: CAM_PRIORITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cam_8x8 #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data0,
  input  logic [DATA_W-1:0] data1,
  input  logic [DATA_W-1:0] data2,
  input  logic [DATA_W-1:0] data3,
  input  logic [DATA_W-1:0] data4,
  input  logic [DATA_W-1:0] data5,
  input  logic [DATA_W-1:0] data6,
  input  logic [DATA_W-1:0] data7,
  input  logic [7:0]        addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              write,
  input  logic              read,
  output logic              srch0,
  output logic              srch1,
  output logic              srch2,
  output logic              srch3,
  output logic              srch4,
  output logic              srch5,
  output logic              srch6,
  output logic              srch7,
  output logic [7:0]        status
`ifdef CAM_PRIORITY_EN
  ,
  output logic              hit,
  output logic [2:0]        hit_idx
`endif
);

  localparam int c_ENTRIES = 8;

  logic [DATA_W-1:0] r_entry [c_ENTRIES];
  logic [7:0]        r_valid;
  logic [7:0]        r_srch;
  logic [DATA_W-1:0] w_data  [c_ENTRIES];
  logic [7:0]        w_match;

  assign w_data[0] = data0;
  assign w_data[1] = data1;
  assign w_data[2] = data2;
  assign w_data[3] = data3;
  assign w_data[4] = data4;
  assign w_data[5] = data5;
  assign w_data[6] = data6;
  assign w_data[7] = data7;

  // Match uses pre-edge contents, so a same-cycle write is not yet searchable.
  generate
    for (genvar g = 0; g < c_ENTRIES; g++) begin : g_match
      assign w_match[g] = r_valid[g] && (r_entry[g] == data_in);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < c_ENTRIES; i++) r_entry[i] <= '0;
      r_valid <= 8'h00;
      r_srch  <= 8'h00;
    end else begin
      if (write) begin
        for (int i = 0; i < c_ENTRIES; i++) begin
          if (addr[i]) begin
            r_entry[i] <= w_data[i];
            r_valid[i] <= 1'b1;
          end
        end
      end
      if (read) r_srch <= w_match;
    end
  end

`ifdef CAM_PRIORITY_EN
  logic       r_hit;
  logic [2:0] r_hit_idx;
  logic [2:0] w_hit_idx;

  always_comb begin
    w_hit_idx = 3'd0;
    for (int i = c_ENTRIES - 1; i >= 0; i--) begin
      if (w_match[i]) w_hit_idx = 3'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hit     <= 1'b0;
      r_hit_idx <= 3'd0;
    end else if (read) begin
      r_hit     <= |w_match;
      r_hit_idx <= w_hit_idx;
    end
  end

  assign hit     = r_hit;
  assign hit_idx = r_hit_idx;
`endif

  assign {srch7, srch6, srch5, srch4, srch3, srch2, srch1, srch0} = r_srch;
  assign status = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_cam_8x8.sv
// ============================================================================
// Module   : tb_cam_8x8
// Purpose  : Directed self-checking bench for cam_8x8.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cam_8x8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data0 = 8'h00, data1 = 8'h00, data2 = 8'h00, data3 = 8'h00;
  logic [7:0] data4 = 8'h00, data5 = 8'h00, data6 = 8'h00, data7 = 8'h00;
  logic [7:0] addr = 8'h00;
  logic [7:0] data_in = 8'h00;
  logic       write = 1'b0;
  logic       read = 1'b0;
  logic       srch0, srch1, srch2, srch3, srch4, srch5, srch6, srch7;
  logic [7:0] status;
`ifdef CAM_PRIORITY_EN
  logic       hit;
  logic [2:0] hit_idx;
`endif

  int checks = 0;
  int errors = 0;

  wire [7:0] w_srch = {srch7, srch6, srch5, srch4, srch3, srch2, srch1, srch0};

  cam_8x8 #(.DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .data0(data0), .data1(data1), .data2(data2), .data3(data3),
    .data4(data4), .data5(data5), .data6(data6), .data7(data7),
    .addr(addr), .data_in(data_in), .write(write), .read(read),
    .srch0(srch0), .srch1(srch1), .srch2(srch2), .srch3(srch3),
    .srch4(srch4), .srch5(srch5), .srch6(srch6), .srch7(srch7),
    .status(status)
`ifdef CAM_PRIORITY_EN
    , .hit(hit), .hit_idx(hit_idx)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_prio(input string tag, input logic exp_hit, input logic [2:0] exp_idx);
`ifdef CAM_PRIORITY_EN
    check({tag, "_hit"}, {7'd0, hit}, {7'd0, exp_hit});
    check({tag, "_idx"}, {5'd0, hit_idx}, {5'd0, exp_idx});
`endif
  endtask

  initial begin
    // Reset with write/read idle
    tick();
    check("rst_status", status, 8'h00);
    check("rst_srch", w_srch, 8'h00);
    check_prio("rst", 1'b0, 3'd0);

    // Invalid entries hold 0 but must not match key 0
    rst = 1'b0; read = 1'b1; data_in = 8'h00;
    tick();
    check("idle_srch00", w_srch, 8'h00);
    read = 1'b0;

    // Masked write AB
    {data0, data1, data2, data3} = {8'hAB, 8'hCB, 8'hAC, 8'hCC};
    {data4, data5, data6, data7} = {8'hAD, 8'hDB, 8'hDC, 8'hFB};
    addr = 8'hAB; write = 1'b1;
    tick();
    check("mask_status", status, 8'hAB);
    write = 1'b0; read = 1'b1; data_in = 8'hAD;
    tick();
    check("mask_srchAD", w_srch, 8'h00);
    read = 1'b0;

    // Load entry 4 and search for single hits
    addr = 8'h10; write = 1'b1;
    tick();
    check("fill_status", status, 8'hBB);
    write = 1'b0; read = 1'b1; data_in = 8'hAD;
    tick();
    check("fill_srchAD", w_srch, 8'h10);
    check_prio("fillAD", 1'b1, 3'd4);
    data_in = 8'hFB;
    tick();
    check("fill_srchFB", w_srch, 8'h80);
    check_prio("fillFB", 1'b1, 3'd7);
    data_in = 8'hCC;
    tick();
    check("fill_srchCC", w_srch, 8'h08);
    read = 1'b0;

    // Overwrite entry 0 with FB: duplicate match
    data0 = 8'hFB; addr = 8'h01; write = 1'b1;
    tick();
    check("dup_status", status, 8'hBB);
    write = 1'b0; read = 1'b1; data_in = 8'hFB;
    tick();
    check("dup_srchFB", w_srch, 8'h81);
    check_prio("dup", 1'b1, 3'd0);
    data_in = 8'hAB;
    tick();
    check("overwritten_AB", w_srch, 8'h00);
    check_prio("miss", 1'b0, 3'd0);

    // Simultaneous write and read: read-before-write
    data2 = 8'h5A; addr = 8'h04; write = 1'b1; read = 1'b1; data_in = 8'h5A;
    tick();
    check("rbw_srch", w_srch, 8'h00);
    check("rbw_status", status, 8'hBF);
    write = 1'b0;
    tick();
    check("rbw_next", w_srch, 8'h04);
    check_prio("rbw", 1'b1, 3'd2);
    read = 1'b0; data_in = 8'hFB;
    tick();
    check("hold_srch", w_srch, 8'h04);
    check_prio("hold", 1'b1, 3'd2);

    // addr=0 write is a no-op
    {data0, data1, data2, data3} = {8'hEE, 8'hEE, 8'hEE, 8'hEE};
    {data4, data5, data6, data7} = {8'hEE, 8'hEE, 8'hEE, 8'hEE};
    addr = 8'h00; write = 1'b1;
    tick();
    check("nop_status", status, 8'hBF);
    write = 1'b0; read = 1'b1; data_in = 8'hEE;
    tick();
    check("nop_srchEE", w_srch, 8'h00);
    data_in = 8'hDB;
    tick();
    check("nop_srchDB", w_srch, 8'h20);
    check_prio("nopDB", 1'b1, 3'd5);

    // Reset overrides write and read
    rst = 1'b1; write = 1'b1; read = 1'b1; addr = 8'hFF; data_in = 8'hDB;
    {data0, data1, data2, data3} = {8'h77, 8'h77, 8'h77, 8'h77};
    {data4, data5, data6, data7} = {8'h77, 8'h77, 8'h77, 8'h77};
    tick();
    check("rst2_status", status, 8'h00);
    check("rst2_srch", w_srch, 8'h00);
    check_prio("rst2", 1'b0, 3'd0);
    rst = 1'b0; write = 1'b0; data_in = 8'h77;
    tick();
    check("rst2_srch77", w_srch, 8'h00);
    check("rst2_status2", status, 8'h00);
    data_in = 8'h00;
    tick();
    check("rst2_srch00", w_srch, 8'h00);
    read = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
